chol_isqrt_arbiter: RTL and testbench

Round-robin arbiter that shares one `chol_inv_sqrt` pipeline among `N_REQ` requesters in the Cholesky datapath; typically these are the column engines that each need 1/sqrt(diagonal). It issues at most one operand per cycle to the unit and records the requester ID in an in-order tag FIFO. When the unit returns a result, the arbiter routes it back to the requester that issued it. The number of in-flight operations is limited to the FIFO depth.

---
 rtl/chol_isqrt_arbiter.sv | 145 ++++++++++++++
 tb/tb_chol_isqrt_arbiter.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/chol_isqrt_arbiter.sv
// Round-robin arbiter sharing one chol_inv_sqrt pipeline among N_REQ requesters.
// Issued requester IDs ride an in-order tag FIFO so each result is routed back to its owner.
module chol_isqrt_arbiter #(
    parameter int N_REQ     = 4,
    parameter int TAG_DEPTH = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           clken,
    input  logic [N_REQ-1:0]               req_valid,
    input  logic [32*N_REQ-1:0]            req_data,
    output logic [N_REQ-1:0]               req_ready,
    output logic                           isq_data_valid,
    output logic [31:0]                    isq_data,
    input  logic                           isq_out_valid,
    input  logic [31:0]                    isq_out,
    output logic [N_REQ-1:0]               resp_valid,
    output logic [31:0]                    resp_data,
    output logic [$clog2(TAG_DEPTH):0]     outstanding,
    output logic                           err_orphan
);

    localparam int PW = $clog2(N_REQ);
    localparam int DW = $clog2(TAG_DEPTH);
    localparam logic [DW:0] DEPTH_C = (DW+1)'(TAG_DEPTH);

    logic [PW-1:0]      rr_ptr_r;
    logic [DW-1:0]      wr_ptr_r;
    logic [DW-1:0]      rd_ptr_r;
    logic [DW:0]        count_r;
    logic [PW-1:0]      tag_mem_r [TAG_DEPTH];
    logic               isq_data_valid_r;
    logic [31:0]        isq_data_r;
    logic [N_REQ-1:0]   resp_valid_r;
    logic [31:0]        resp_data_r;
    logic               err_orphan_r;

    logic [N_REQ-1:0]   grant_s;
    logic [PW-1:0]      grant_idx_s;
    logic [31:0]        grant_data_s;
    logic               found_s;
    logic               eligible_s;
    logic               push_s;
    logic               pop_s;
    logic               orphan_s;
    logic [PW-1:0]      head_s;

    // Round-robin scan starting at rr_ptr; first valid requester wins.
    always_comb begin
        int idx;
        grant_s      = '0;
        grant_idx_s  = '0;
        grant_data_s = 32'h0000_0000;
        found_s      = 1'b0;
        idx          = 0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = (int'(rr_ptr_r) + k) % N_REQ;
            if (!found_s && req_valid[idx]) begin
                found_s      = 1'b1;
                grant_s[idx] = 1'b1;
                grant_idx_s  = PW'(idx);
                grant_data_s = req_data[32*idx +: 32];
            end else begin
                found_s = found_s;
            end
        end
    end

    // Eligibility uses the registered count only, so a same-cycle pop frees nothing early.
    always_comb begin
        eligible_s = (count_r < DEPTH_C) && clken && !rst;
        if (eligible_s) begin
            req_ready = grant_s;
        end else begin
            req_ready = '0;
        end
        push_s   = eligible_s && found_s;
        pop_s    = clken && isq_out_valid && (count_r != '0);
        orphan_s = clken && isq_out_valid && (count_r == '0);
        head_s   = tag_mem_r[rd_ptr_r];
    end

    // Tag storage; contents are meaningless outside the rd..wr window so no reset is needed.
    always_ff @(posedge clk) begin
        if (push_s) begin
            tag_mem_r[wr_ptr_r] <= grant_idx_s;
        end
    end

    // Arbitration pointer, FIFO pointers and occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_r <= '0;
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else if (clken) begin
            if (push_s) begin
                rr_ptr_r <= (grant_idx_s == PW'(N_REQ-1)) ? '0 : grant_idx_s + PW'(1);
                wr_ptr_r <= wr_ptr_r + DW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + DW'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + (DW+1)'(1);
                2'b01:   count_r <= count_r - (DW+1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Issue and return registers; pulses hold while clken is low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            isq_data_valid_r <= 1'b0;
            isq_data_r       <= 32'h0000_0000;
            resp_valid_r     <= '0;
            resp_data_r      <= 32'h0000_0000;
            err_orphan_r     <= 1'b0;
        end else if (clken) begin
            isq_data_valid_r <= push_s;
            if (push_s) begin
                isq_data_r <= grant_data_s;
            end
            if (pop_s) begin
                resp_valid_r <= N_REQ'(1'b1) << head_s;
                resp_data_r  <= isq_out;
            end else begin
                resp_valid_r <= '0;
            end
            if (orphan_s) begin
                err_orphan_r <= 1'b1;
            end
        end
    end

    assign isq_data_valid = isq_data_valid_r;
    assign isq_data       = isq_data_r;
    assign resp_valid     = resp_valid_r;
    assign resp_data      = resp_data_r;
    assign outstanding    = count_r;
    assign err_orphan     = err_orphan_r;

endmodule

// File: tb/tb_chol_isqrt_arbiter.sv
// Directed bench for chol_isqrt_arbiter with a small in-order inverse-sqrt pipeline model
// (latency 6, deliberately longer than the 4-entry tag FIFO to exercise back-pressure).
module tb_chol_isqrt_arbiter;

    localparam int N_REQ = 4;
    localparam int TAG_DEPTH = 4;
    localparam int LAT = 6;

    logic               clk = 1'b0;
    logic               rst;
    logic               clken;
    logic [N_REQ-1:0]   req_valid;
    logic [32*N_REQ-1:0] req_data;
    logic [N_REQ-1:0]   req_ready;
    logic               isq_data_valid;
    logic [31:0]        isq_data;
    logic               isq_out_valid;
    logic [31:0]        isq_out;
    logic [N_REQ-1:0]   resp_valid;
    logic [31:0]        resp_data;
    logic [2:0]         outstanding;
    logic               err_orphan;

    logic               inj_valid;
    logic [31:0]        inj_data;
    logic [32:0]        pipe [LAT];

    int errors = 0;
    int checks = 0;

    chol_isqrt_arbiter #(.N_REQ(N_REQ), .TAG_DEPTH(TAG_DEPTH)) dut (
        .clk(clk), .rst(rst), .clken(clken),
        .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
        .isq_data_valid(isq_data_valid), .isq_data(isq_data),
        .isq_out_valid(isq_out_valid), .isq_out(isq_out),
        .resp_valid(resp_valid), .resp_data(resp_data),
        .outstanding(outstanding), .err_orphan(err_orphan)
    );

    always #5 clk = ~clk;

    // Hand-tabulated 1/sqrt(x) in Q16.16 for the operands used below.
    function automatic logic [31:0] isq_model(input logic [31:0] d);
        case (d)
            32'h0002_0000: isq_model = 32'h0000_B505;
            32'h0004_0000: isq_model = 32'h0000_8000;
            32'h0064_8000: isq_model = 32'h0000_1989;
            32'h0001_0000: isq_model = 32'h0001_0000;
            default:       isq_model = d ^ 32'h5A5A_5A5A;
        endcase
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < LAT; i++) pipe[i] <= '0;
        end else if (clken) begin
            pipe[0] <= {isq_data_valid, isq_data};
            for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
        end
    end

    assign isq_out_valid = pipe[LAT-1][32] | inj_valid;
    assign isq_out = inj_valid ? inj_data : isq_model(pipe[LAT-1][31:0]);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wait_resp(input string tag, input logic [3:0] exp_v, input logic [31:0] exp_d);
        int n;
        n = 0;
        while (resp_valid == 4'b0000 && n < 20) begin
            tick();
            n++;
        end
        chk({tag, "_valid"}, {28'h0, resp_valid}, {28'h0, exp_v});
        chk({tag, "_data"}, resp_data, exp_d);
        tick();
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
    endtask

    initial begin
        int gcnt;
        int n;
        int bad;
        logic [3:0] grants [4];

        rst = 1'b1; clken = 1'b1; req_valid = 4'hF; req_data = '0;
        inj_valid = 1'b0; inj_data = 32'h0;
        tick(); tick();
        chk("rst_req_ready", {28'h0, req_ready}, 32'h0);
        chk("rst_isq_valid", {31'h0, isq_data_valid}, 32'h0);
        chk("rst_isq_data", isq_data, 32'h0);
        chk("rst_resp_valid", {28'h0, resp_valid}, 32'h0);
        chk("rst_resp_data", resp_data, 32'h0);
        chk("rst_outstanding", {29'h0, outstanding}, 32'h0);
        chk("rst_err_orphan", {31'h0, err_orphan}, 32'h0);
        req_valid = 4'h0;
        rst = 1'b0;
        tick();

        // Single request from requester 0
        req_data = {32'h0001_0000, 32'h0064_8000, 32'h0004_0000, 32'h0002_0000};
        req_valid = 4'b0001;
        #1 chk("single_ready", {28'h0, req_ready}, 32'h1);
        tick();
        req_valid = 4'b0000;
        chk("single_issue_valid", {31'h0, isq_data_valid}, 32'h1);
        chk("single_issue_data", isq_data, 32'h0002_0000);
        chk("single_outstanding", {29'h0, outstanding}, 32'h1);
        tick();
        chk("single_issue_pulse", {31'h0, isq_data_valid}, 32'h0);
        wait_resp("single_resp", 4'b0001, 32'h0000_B505);

        // Contention, rr_ptr back at 0
        pulse_reset();
        req_valid = 4'b1111;
        #1 chk("cont_g0", {28'h0, req_ready}, 32'h1);
        tick(); req_valid = 4'b1110;
        #1 chk("cont_g1", {28'h0, req_ready}, 32'h2);
        tick(); req_valid = 4'b1100;
        #1 chk("cont_g2", {28'h0, req_ready}, 32'h4);
        tick(); req_valid = 4'b1000;
        #1 chk("cont_g3", {28'h0, req_ready}, 32'h8);
        tick(); req_valid = 4'b0000;
        chk("cont_outstanding", {29'h0, outstanding}, 32'h4);
        wait_resp("cont_r0", 4'b0001, 32'h0000_B505);
        wait_resp("cont_r1", 4'b0010, 32'h0000_8000);
        wait_resp("cont_r2", 4'b0100, 32'h0000_1989);
        wait_resp("cont_r3", 4'b1000, 32'h0001_0000);

        // Fairness: 1 and 3 held valid
        req_data = {32'h0004_0000, 32'h0, 32'h0001_0000, 32'h0};
        req_valid = 4'b1010;
        gcnt = 0;
        n = 0;
        while (gcnt < 4 && n < 30) begin
            #1;
            if (req_ready != 4'b0000) begin
                grants[gcnt] = req_ready;
                gcnt++;
            end
            tick();
            n++;
        end
        req_valid = 4'b0000;
        chk("fair_count", gcnt, 4);
        chk("fair_g0", {28'h0, grants[0]}, 32'h2);
        chk("fair_g1", {28'h0, grants[1]}, 32'h8);
        chk("fair_g2", {28'h0, grants[2]}, 32'h2);
        chk("fair_g3", {28'h0, grants[3]}, 32'h8);
        wait_resp("fair_r0", 4'b0010, 32'h0001_0000);
        wait_resp("fair_r1", 4'b1000, 32'h0000_8000);
        wait_resp("fair_r2", 4'b0010, 32'h0001_0000);
        wait_resp("fair_r3", 4'b1000, 32'h0000_8000);

        // Back-pressure: requester 2 always valid
        req_data = {32'h0, 32'h0001_0000, 32'h0, 32'h0};
        req_valid = 4'b0100;
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            #1;
            if (req_ready != 4'b0100) bad++;
            tick();
        end
        chk("bp_four_grants", bad, 0);
        chk("bp_full", {29'h0, outstanding}, 32'h4);
        n = 0;
        bad = 0;
        while (resp_valid == 4'b0000 && n < 20) begin
            #1;
            if (req_ready != 4'b0000 || outstanding != 3'd4) bad++;
            tick();
            n++;
        end
        chk("bp_stall", bad, 0);
        chk("bp_first_resp", {28'h0, resp_valid}, 32'h4);
        chk("bp_first_data", resp_data, 32'h0001_0000);
        chk("bp_refill_ready", {28'h0, req_ready}, 32'h4);
        tick();
        req_valid = 4'b0000;
        chk("bp_steady_count", {29'h0, outstanding}, 32'h3);
        wait_resp("bp_r1", 4'b0100, 32'h0001_0000);
        wait_resp("bp_r2", 4'b0100, 32'h0001_0000);
        wait_resp("bp_r3", 4'b0100, 32'h0001_0000);
        wait_resp("bp_r4", 4'b0100, 32'h0001_0000);
        chk("bp_drained", {29'h0, outstanding}, 32'h0);

        // Orphan result
        inj_valid = 1'b1; inj_data = 32'h0000_DEAD;
        tick();
        inj_valid = 1'b0;
        chk("orphan_flag", {31'h0, err_orphan}, 32'h1);
        chk("orphan_no_resp", {28'h0, resp_valid}, 32'h0);
        tick();
        chk("orphan_sticky", {31'h0, err_orphan}, 32'h1);
        chk("orphan_count", {29'h0, outstanding}, 32'h0);

        // Reset with three outstanding
        req_data = {32'h0, 32'h0, 32'h0, 32'h0004_0000};
        req_valid = 4'b0001;
        tick(); tick(); tick();
        req_valid = 4'b0000;
        chk("mid_outstanding", {29'h0, outstanding}, 32'h3);
        #2 rst = 1'b1;
        #1;
        chk("async_outstanding", {29'h0, outstanding}, 32'h0);
        chk("async_err", {31'h0, err_orphan}, 32'h0);
        chk("async_isq_valid", {31'h0, isq_data_valid}, 32'h0);
        chk("async_isq_data", isq_data, 32'h0);
        chk("async_resp_data", resp_data, 32'h0);
        tick();
        rst = 1'b0;
        bad = 0;
        for (int i = 0; i < 15; i++) begin
            if (resp_valid != 4'b0000) bad++;
            tick();
        end
        chk("no_stale_resp", bad, 0);

        // Clock enable dropped for 5 cycles mid-stream
        req_data = {32'h0001_0000, 32'h0064_8000, 32'h0004_0000, 32'h0002_0000};
        req_valid = 4'b1111;
        tick(); req_valid = 4'b1110;
        tick(); req_valid = 4'b1100;
        clken = 1'b0;
        #1 chk("ce_no_grant", {28'h0, req_ready}, 32'h0);
        for (int i = 0; i < 5; i++) tick();
        chk("ce_hold_valid", {31'h0, isq_data_valid}, 32'h1);
        chk("ce_hold_data", isq_data, 32'h0004_0000);
        chk("ce_hold_count", {29'h0, outstanding}, 32'h2);
        clken = 1'b1;
        #1 chk("ce_resume", {28'h0, req_ready}, 32'h4);
        tick(); req_valid = 4'b1000;
        tick(); req_valid = 4'b0000;
        wait_resp("ce_r0", 4'b0001, 32'h0000_B505);
        wait_resp("ce_r1", 4'b0010, 32'h0000_8000);
        n = 0;
        while (resp_valid == 4'b0000 && n < 20) begin
            tick();
            n++;
        end
        clken = 1'b0;
        tick(); tick(); tick();
        chk("ce_hold_resp", {28'h0, resp_valid}, 32'h4);
        chk("ce_hold_rdata", resp_data, 32'h0000_1989);
        clken = 1'b1;
        tick();
        wait_resp("ce_r3", 4'b1000, 32'h0001_0000);
        chk("ce_drained", {29'h0, outstanding}, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
